ifns_code_rx_fifo: RTL and testbench

//  Receive-side elastic buffer for 33-bit IFNS code words arriving from the TSV link.

---
 rtl/ifns_code_rx_fifo_if.sv | 11 +
 rtl/ifns_code_rx_fifo.sv | 69 ++++++
 tb/tb_ifns_code_rx_fifo.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ifns_code_rx_fifo_if.sv
// ifns_code_rx_fifo_if: link-side and decoder-side valid/ready handshake for the IFNS RX FIFO.
interface ifns_code_rx_fifo_if #(parameter int CODE_W = 33);
   logic              in_valid;
   logic              in_ready;
   logic [CODE_W:1]   in_code;
   logic              out_valid;
   logic              out_ready;
   logic [CODE_W:1]   out_code;
   modport master (output in_valid, in_code, out_ready, input in_ready, out_valid, out_code);
   modport slave  (input in_valid, in_code, out_ready, output in_ready, out_valid, out_code);
endinterface

// File: rtl/ifns_code_rx_fifo.sv
// ifns_code_rx_fifo: show-ahead elastic buffer feeding the IFNS decoder codein[33:1].
// Optional statistics counters built only when IFNS_RX_STATS_EN is defined.
module ifns_code_rx_fifo #(
   parameter int CODE_W = 33,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic                 flush,
   ifns_code_rx_fifo_if.slave   bus,
   output logic [ADDR_W:0]      level,
   output logic [15:0]          word_cnt,
   output logic [15:0]          stall_cnt
);
   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
   logic [CODE_W:1]   mem_q [DEPTH];
   logic [CODE_W:1]   mem_d [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              push, pop;
   assign bus.in_ready  = (level_q != FULL) & ~flush & ~rst;
   assign bus.out_valid = level_q != '0;
   assign bus.out_code  = bus.out_valid ? mem_q[rd_ptr_q] : '0;
   assign level         = level_q;
   // Flush discards whatever handshake happens in its cycle.
   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready & ~flush;
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = bus.in_code;
      wr_ptr_d = flush ? '0 : wr_ptr_q + ADDR_W'(push);
      rd_ptr_d = flush ? '0 : rd_ptr_q + ADDR_W'(pop);
      level_d  = flush ? '0 : level_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
   end
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end
`ifdef IFNS_RX_STATS_EN
   logic [15:0] word_cnt_q, word_cnt_d, stall_cnt_q, stall_cnt_d;
   always_comb begin
      word_cnt_d  = word_cnt_q + 16'(pop && word_cnt_q != 16'hFFFF);
      stall_cnt_d = stall_cnt_q + 16'(bus.in_valid && !bus.in_ready && stall_cnt_q != 16'hFFFF);
   end
   always_ff @(posedge clock) begin
      if (rst) begin
         word_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         word_cnt_q  <= word_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
   assign word_cnt  = word_cnt_q;
   assign stall_cnt = stall_cnt_q;
`else
   assign word_cnt  = '0;
   assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_ifns_code_rx_fifo.sv
// tb_ifns_code_rx_fifo: directed + random stimulus against a queue-based FIFO model.
module tb_ifns_code_rx_fifo;
   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [2:0]  level;
   logic [15:0] word_cnt, stall_cnt;
   int          n_chk = 0;
   int          n_fail = 0;
   bit          chk_en = 1'b0;
   logic [33:1] mq[$];
   int          m_word = 0;
   int          m_stall = 0;
`ifdef IFNS_RX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   ifns_code_rx_fifo_if #(.CODE_W(33)) bus ();
   ifns_code_rx_fifo dut (
      .clock     (clock),
      .rst       (rst),
      .flush     (flush),
      .bus       (bus),
      .level     (level),
      .word_cnt  (word_cnt),
      .stall_cnt (stall_cnt)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [33:1] rnd_code();
      return {1'($urandom), 32'($urandom)};
   endfunction
   // Drive one cycle, check outputs against the model, then advance the model.
   task automatic step(input logic r, input logic fl, input logic iv, input logic [33:1] c, input logic ordy);
      int   n;
      logic exp_rdy;
      logic [33:1] exp_code;
      @(negedge clock);
      rst = r;
      flush = fl;
      bus.in_valid = iv;
      bus.in_code = c;
      bus.out_ready = ordy;
      #1;
      n = mq.size();
      exp_rdy = (n < 4) && !fl && !r;
      exp_code = '0;
      if (n > 0) exp_code = mq[0];
      if (chk_en) begin
         chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
         chk("out_valid", 64'(bus.out_valid), 64'(n > 0));
         chk("out_code", 64'(bus.out_code), 64'(exp_code));
         chk("level", 64'(level), 64'(n));
         chk("word_cnt", 64'(word_cnt), STATS ? 64'(m_word) : 64'd0);
         chk("stall_cnt", 64'(stall_cnt), STATS ? 64'(m_stall) : 64'd0);
      end
      if (r) begin
         mq.delete();
         m_word = 0;
         m_stall = 0;
      end else begin
         if (iv && !exp_rdy && m_stall < 65535) m_stall++;
         if (fl) mq.delete();
         else begin
            if (n > 0 && ordy) begin
               void'(mq.pop_front());
               if (m_word < 65535) m_word++;
            end
            if (iv && exp_rdy) mq.push_back(c);
         end
      end
   endtask
   initial begin
      logic [33:1] w [5];
      bus.in_valid = 1'b0;
      bus.in_code = '0;
      bus.out_ready = 1'b0;
      step(1, 0, 0, '0, 0);
      chk_en = 1'b1;
      // reset with link pushing
      step(1, 0, 1, rnd_code(), 0);
      step(1, 0, 1, rnd_code(), 0);
      // latency: push into empty, visible next cycle
      step(0, 0, 1, 33'h1_5555_5555, 0);
      step(0, 0, 0, '0, 0);
      chk("t2_code", 64'(bus.out_code), 64'h1_5555_5555);
      chk("t2_level", 64'(level), 64'd1);
      // fill past full with the fifth word held by the link
      step(0, 1, 0, '0, 0);
      foreach (w[i]) w[i] = rnd_code();
      for (int i = 0; i < 5; i++) step(0, 0, 1, w[i], 0);
      chk("t3_full_ready", 64'(bus.in_ready), 64'd0);
      step(0, 0, 1, w[4], 0);
      step(0, 0, 1, w[4], 1);
      chk("t4_full_pop_level", 64'(level), 64'd4);
      step(0, 0, 1, w[4], 0);
      chk("t4_after_pop_level", 64'(level), 64'd3);
      chk("t3_order2", 64'(bus.out_code), 64'(w[1]));
      for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 1);
      // simultaneous push and pop at level 2
      for (int i = 0; i < 2; i++) step(0, 0, 1, rnd_code(), 0);
      step(0, 0, 1, rnd_code(), 1);
      step(0, 0, 0, '0, 0);
      chk("t4_sim_level", 64'(level), 64'd2);
      for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1);
      // flush with push and pop attempted
      for (int i = 0; i < 3; i++) step(0, 0, 1, rnd_code(), 0);
      step(0, 1, 1, rnd_code(), 1);
      step(0, 0, 0, '0, 0);
      chk("t5_level", 64'(level), 64'd0);
      chk("t5_code", 64'(bus.out_code), 64'd0);
      // random traffic
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0, 1'($urandom), rnd_code(), 1'($urandom));
      // stall counting from a fresh reset
      step(1, 0, 0, '0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, rnd_code(), 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, rnd_code(), 0);
      step(0, 0, 0, '0, 0);
      chk("t6_stall", 64'(stall_cnt), STATS ? 64'd3 : 64'd0);
      if (STATS) begin
         for (int i = 0; i < 70000; i++) step(0, 0, 1, rnd_code(), 1);
         step(0, 0, 0, '0, 0);
         chk("t6_word_sat", 64'(word_cnt), 64'hFFFF);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
